xc20xx_cfg_loader: RTL and testbench

Serial configuration controller for an XC20XX CLB array. It parses the XC20XX bitstream (preamble, 24-bit length count, framed data) arriving one bit per enabled clock. Each checked frame is emitted as a parallel word with an address and write strobe, which the configuration memory uses to load the CLB parameters (F_INIT, G_INIT, MUX_FG, MODE, XMUX/YMUX selects). The block sits between the configuration pin interface and the frame-addressed configuration store.

---
 rtl/xc20xx_cfg_loader_if.sv | 45 ++++
 rtl/xc20xx_cfg_loader.sv | 162 ++++++++++++++++
 tb/tb_xc20xx_cfg_loader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xc20xx_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// xc20xx_cfg_loader_if
// Bundles the serial configuration pins and the frame-write bus of the
// XC20XX configuration loader.
//
//   CE, DIN      : serial side. DIN is consumed only in cycles where CE=1.
//   FRAME_DATA   : last completed frame, first-received bit in the MSB.
//   FRAME_ADDR   : 0-based index of the frame held in FRAME_DATA.
//   FRAME_WE     : one-cycle write strobe for FRAME_DATA/FRAME_ADDR.
//   LENGTH       : captured 24-bit length count (informational).
//   BUSY/DONE/ERR: loader status. DONE and ERR are sticky until reset.
//   STATE_DBG    : current loader state, for observation only.
//
// Handshake: FRAME_WE is a valid-only strobe. The configuration store is
// always ready, so a frame transfers in the single cycle FRAME_WE is high,
// and FRAME_DATA/FRAME_ADDR stay stable until the next strobe.
//
// modport master : the side that drives the bitstream (pins / testbench).
// modport slave  : the loader itself.
// ---------------------------------------------------------------------------
interface xc20xx_cfg_loader_if #(
  parameter int FRAME_BITS = 71,
  parameter int ADDR_W     = 6
);
  logic                  CE;
  logic                  DIN;
  logic [FRAME_BITS-1:0] FRAME_DATA;
  logic [ADDR_W-1:0]     FRAME_ADDR;
  logic                  FRAME_WE;
  logic [23:0]           LENGTH;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;
  logic [2:0]            STATE_DBG;

  modport master (
    output CE, DIN,
    input  FRAME_DATA, FRAME_ADDR, FRAME_WE, LENGTH, BUSY, DONE, ERR, STATE_DBG
  );

  modport slave (
    input  CE, DIN,
    output FRAME_DATA, FRAME_ADDR, FRAME_WE, LENGTH, BUSY, DONE, ERR, STATE_DBG
  );
endinterface

// File: rtl/xc20xx_cfg_loader.sv
// ---------------------------------------------------------------------------
// xc20xx_cfg_loader
// Serial configuration controller for an XC20XX CLB array. It parses the
// bitstream (0010 preamble, 24-bit length count, framed data) one bit per
// enabled clock, and emits each checked frame as a parallel word with an
// address and a one-cycle write strobe for the configuration store.
//
// Ports:
//   K    : clock, all state updates on the rising edge.
//   RST  : asynchronous, active-high reset.
//   bus  : xc20xx_cfg_loader_if.slave (CE, DIN in; frame bus and status out).
//
// Frame format after the length count: start bit 0, FRAME_BITS data bits
// (MSB first), three stop bits of 1. Before frame 0 any number of 1s may
// stand in for the start bit; after frame 0 a 1 there is a framing error.
// ---------------------------------------------------------------------------
module xc20xx_cfg_loader #(
  parameter int FRAME_BITS = 71,
  parameter int NUM_FRAMES = 46,
  parameter int ADDR_W     = 6
) (
  input  logic                 K,
  input  logic                 RST,
  xc20xx_cfg_loader_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam int               BW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BW-1:0]    BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(NUM_FRAMES - 1);

  logic [2:0]            state_q,      state_d;
  // Only the three most recent bits are kept: together with the incoming
  // DIN they form the 4-bit preamble window. Reset value 3'b111 is the
  // all-ones window, so nothing before the first real bits can match.
  logic [2:0]            win_q,        win_d;
  logic [4:0]            len_cnt_q,    len_cnt_d;
  logic [BW-1:0]         bit_cnt_q,    bit_cnt_d;
  logic [1:0]            stop_cnt_q,   stop_cnt_d;
  logic [ADDR_W-1:0]     frame_idx_q,  frame_idx_d;
  logic [FRAME_BITS-1:0] shift_q,      shift_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic [ADDR_W-1:0]     frame_addr_q, frame_addr_d;
  logic                  we_q,         we_d;
  logic [23:0]           length_q,     length_d;

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    len_cnt_d    = len_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    frame_idx_d  = frame_idx_q;
    shift_d      = shift_q;
    frame_data_d = frame_data_q;
    frame_addr_d = frame_addr_q;
    length_d     = length_q;
    // The strobe is a pulse independent of CE.
    we_d         = 1'b0;

    if (bus.CE) begin
      case (state_q)
        S_IDLE: begin
          win_d = {win_q[1:0], bus.DIN};
          if ({win_q, bus.DIN} == 4'b0010) begin
            state_d   = S_LEN;
            len_cnt_d = '0;
          end
        end
        S_LEN: begin
          length_d = {length_q[22:0], bus.DIN};
          if (len_cnt_q == 5'd23) begin
            state_d = S_START;
          end else begin
            len_cnt_d = len_cnt_q + 5'd1;
          end
        end
        S_START: begin
          if (!bus.DIN) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else if (frame_idx_q != '0) begin
            state_d = S_ERR;
          end
        end
        S_DATA: begin
          shift_d = {shift_q[FRAME_BITS-2:0], bus.DIN};
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = S_STOP;
            stop_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        S_STOP: begin
          if (!bus.DIN) begin
            state_d = S_ERR;
          end else if (stop_cnt_q == 2'd2) begin
            frame_data_d = shift_q;
            frame_addr_d = frame_idx_q;
            we_d         = 1'b1;
            frame_idx_d  = frame_idx_q + ADDR_W'(1);
            state_d      = (frame_idx_q == FRAME_LAST) ? S_DONE : S_START;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
        // DONE and ERR absorb all further bits until reset.
        default: ;
      endcase
    end
  end

  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      win_q        <= 3'b111;
      len_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      frame_idx_q  <= '0;
      shift_q      <= '0;
      frame_data_q <= '0;
      frame_addr_q <= '0;
      we_q         <= 1'b0;
      length_q     <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      len_cnt_q    <= len_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      frame_idx_q  <= frame_idx_d;
      shift_q      <= shift_d;
      frame_data_q <= frame_data_d;
      frame_addr_q <= frame_addr_d;
      we_q         <= we_d;
      length_q     <= length_d;
    end
  end

  // Status is decoded from the registered state, so BUSY rises the cycle
  // after the preamble completes and DONE/ERR the cycle after the deciding
  // bit; DONE and ERR are distinct states and can never be high together.
  assign bus.BUSY       = (state_q == S_LEN) || (state_q == S_START) ||
                          (state_q == S_DATA) || (state_q == S_STOP);
  assign bus.DONE       = (state_q == S_DONE);
  assign bus.ERR        = (state_q == S_ERR);
  assign bus.FRAME_DATA = frame_data_q;
  assign bus.FRAME_ADDR = frame_addr_q;
  assign bus.FRAME_WE   = we_q;
  assign bus.LENGTH     = length_q;
  assign bus.STATE_DBG  = state_q;

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_xc20xx_cfg_loader
// Bench for the XC20XX configuration loader with FRAME_BITS=8, NUM_FRAMES=2.
// A bitstream is assembled as a queue of bits; a reference parser walks that
// queue and pushes every frame write it implies into exp_q, together with
// the final LENGTH/DONE/ERR/BUSY. A monitor pops exp_q on each FRAME_WE.
// ---------------------------------------------------------------------------
module tb_xc20xx_cfg_loader;
  localparam int FB = 8;
  localparam int NF = 2;
  localparam int AW = 6;
  localparam int W  = AW + FB;
  localparam int ST_RUN  = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  // ---------------- clock / reset ----------------
  logic K   = 1'b0;
  logic RST = 1'b1;
  always #5 K = ~K;

  xc20xx_cfg_loader_if #(.FRAME_BITS(FB), .ADDR_W(AW)) bus ();

  xc20xx_cfg_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .ADDR_W(AW)) dut (
    .K   (K),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  bit            stim_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [23:0]   exp_len;
  int            exp_status;
  int            pre_end;
  int            end_pos;
  logic [AW-1:0] exp_last_addr;
  logic [FB-1:0] exp_last_data;
  bit            prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge K) begin
    if (bus.FRAME_WE === 1'b1) begin
      check("we_width", {63'd0, prev_we}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", {{(64-W){1'b0}}, bus.FRAME_ADDR, bus.FRAME_DATA}, 64'hDEAD);
      end else begin
        check("frame_write", {{(64-W){1'b0}}, bus.FRAME_ADDR, bus.FRAME_DATA},
              {{(64-W){1'b0}}, exp_q.pop_front()});
      end
    end
    if (bus.DONE === 1'b1 || bus.ERR === 1'b1)
      check("done_err_exclusive", {63'd0, bus.DONE & bus.ERR}, 64'd0);
    prev_we = bus.FRAME_WE;
  end

  // ---------------- reference model ----------------
  // Parses stim_q as the configuration pins would see it and records what
  // the loader must produce.
  task automatic model_stream();
    int n;
    int p;
    int f;
    int got;
    bit ok;
    logic [FB-1:0] d;
    n = stim_q.size();
    exp_len = '0;
    exp_status = ST_RUN;
    pre_end = -1;
    end_pos = -1;
    exp_last_addr = '0;
    exp_last_data = '0;
    for (int i = 3; i < n; i++) begin
      if (!stim_q[i-3] && !stim_q[i-2] && stim_q[i-1] && !stim_q[i]) begin
        pre_end = i;
        break;
      end
    end
    if (pre_end < 0) return;
    p = pre_end + 1;
    got = 0;
    while (got < 24 && p < n) begin
      exp_len = {exp_len[22:0], stim_q[p]};
      p++;
      got++;
    end
    if (got < 24) return;
    f = 0;
    while (p < n && exp_status == ST_RUN) begin
      if (stim_q[p]) begin
        if (f == 0) begin
          p++;
          continue;
        end
        exp_status = ST_ERR;
        end_pos = p;
        break;
      end
      p++;
      if (p + FB > n) break;
      d = '0;
      for (int k = 0; k < FB; k++) begin
        d = {d[FB-2:0], stim_q[p]};
        p++;
      end
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (p >= n) begin
          ok = 1'b0;
          break;
        end
        if (!stim_q[p]) begin
          exp_status = ST_ERR;
          end_pos = p;
          ok = 1'b0;
          break;
        end
        p++;
      end
      if (!ok) break;
      exp_q.push_back({AW'(f), d});
      exp_last_addr = AW'(f);
      exp_last_data = d;
      f++;
      if (f == NF) begin
        exp_status = ST_DONE;
        end_pos = p - 1;
      end
    end
  endtask

  // ---------------- stream builders ----------------
  task automatic push_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stim_q.push_back(v[k]);
  endtask

  task automatic push_frame(input logic [FB-1:0] d, input bit sb, input logic [2:0] stop);
    stim_q.push_back(sb);
    push_bits({24'd0, d}, FB);
    push_bits({29'd0, stop}, 3);
  endtask

  task automatic push_postamble();
    for (int k = 0; k < 8; k++) stim_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_frame_data"}, {56'd0, bus.FRAME_DATA}, 64'd0);
    check({tag, "_frame_addr"}, {58'd0, bus.FRAME_ADDR}, 64'd0);
    check({tag, "_frame_we"},   {63'd0, bus.FRAME_WE},   64'd0);
    check({tag, "_length"},     {40'd0, bus.LENGTH},     64'd0);
    check({tag, "_busy"},       {63'd0, bus.BUSY},       64'd0);
    check({tag, "_done"},       {63'd0, bus.DONE},       64'd0);
    check({tag, "_err"},        {63'd0, bus.ERR},        64'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.CE = 1'b0;
    bus.DIN = 1'b0;
    repeat (2) @(posedge K);
    #1;
    check_zero("reset");
    exp_q.delete();
    RST = 1'b0;
    @(posedge K);
    #1;
  endtask

  // mode 0: CE held high, 1: CE toggled, 2: random gaps of 0..3 cycles.
  task automatic run_stream(input int mode, input bit final_chk);
    int gap;
    model_stream();
    for (int i = 0; i < stim_q.size(); i++) begin
      bus.CE = 1'b1;
      bus.DIN = stim_q[i];
      @(posedge K);
      #1;
      if (i == pre_end) check("busy_after_preamble", {63'd0, bus.BUSY}, 64'd1);
      if (i == end_pos) begin
        check("done_at_end", {63'd0, bus.DONE}, {63'd0, exp_status == ST_DONE});
        check("err_at_end",  {63'd0, bus.ERR},  {63'd0, exp_status == ST_ERR});
        check("busy_at_end", {63'd0, bus.BUSY}, 64'd0);
      end
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
      if (gap > 0) begin
        bus.CE = 1'b0;
        bus.DIN = 1'($urandom_range(0, 1));
        repeat (gap) @(posedge K);
        #1;
      end
    end
    bus.CE = 1'b0;
    if (final_chk) begin
      repeat (4) @(posedge K);
      #1;
      check("final_length", {40'd0, bus.LENGTH}, {40'd0, exp_len});
      check("final_done", {63'd0, bus.DONE}, {63'd0, exp_status == ST_DONE});
      check("final_err",  {63'd0, bus.ERR},  {63'd0, exp_status == ST_ERR});
      check("final_busy", {63'd0, bus.BUSY}, {63'd0, exp_status == ST_RUN && pre_end >= 0});
      check("hold_addr",  {58'd0, bus.FRAME_ADDR}, {58'd0, exp_last_addr});
      check("hold_data",  {56'd0, bus.FRAME_DATA}, {56'd0, exp_last_data});
      check("pending_writes", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic build_directed(input bit noise);
    stim_q.delete();
    if (noise) push_bits(32'b1011, 4);
    else       push_bits(32'b1111, 4);
    push_bits(32'b0010, 4);
    push_bits(32'h000020, 24);
    if (noise) push_bits(32'b111, 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mode;
    int corr;
    int bad_f;
    logic [2:0] stop;
    bus.CE = 1'b0;
    bus.DIN = 1'b0;
    do_reset();

    // Basic load, CE held high.
    build_directed(1'b0);
    push_frame(8'hA5, 1'b0, 3'b111);
    push_frame(8'h3C, 1'b0, 3'b111);
    push_postamble();
    run_stream(0, 1'b1);
    check("t1_length_const", {40'd0, bus.LENGTH}, 64'h20);

    // Same stream, CE toggling.
    do_reset();
    build_directed(1'b0);
    push_frame(8'hA5, 1'b0, 3'b111);
    push_frame(8'h3C, 1'b0, 3'b111);
    push_postamble();
    run_stream(1, 1'b1);

    // Second stop bit of frame 0 is 0.
    do_reset();
    build_directed(1'b0);
    push_frame(8'hA5, 1'b0, 3'b101);
    push_frame(8'h3C, 1'b0, 3'b111);
    run_stream(0, 1'b1);

    // Start bit of frame 1 is 1.
    do_reset();
    build_directed(1'b0);
    push_frame(8'hA5, 1'b0, 3'b111);
    push_frame(8'h3C, 1'b1, 3'b111);
    run_stream(0, 1'b1);

    // Leading noise and dummy 1s before frame 0.
    do_reset();
    build_directed(1'b1);
    push_frame(8'hA5, 1'b0, 3'b111);
    push_frame(8'h3C, 1'b0, 3'b111);
    run_stream(0, 1'b1);

    // Asynchronous reset in the middle of frame 1 data, then full reload.
    do_reset();
    build_directed(1'b0);
    push_frame(8'hA5, 1'b0, 3'b111);
    stim_q.push_back(1'b0);
    push_bits(32'b1001, 4);
    run_stream(0, 1'b0);
    #3;
    RST = 1'b1;
    #1;
    check_zero("async_reset");
    check("flushed_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge K);
    #1;
    RST = 1'b0;
    @(posedge K);
    #1;
    build_directed(1'b0);
    push_frame(8'h5A, 1'b0, 3'b111);
    push_frame(8'hC3, 1'b0, 3'b111);
    push_postamble();
    run_stream(2, 1'b1);

    // Randomized streams.
    for (int it = 0; it < 24; it++) begin
      do_reset();
      stim_q.delete();
      for (int k = 0; k < int'($urandom_range(0, 6)); k++)
        stim_q.push_back(1'($urandom_range(0, 1)));
      push_bits(32'b0010, 4);
      push_bits($urandom, 24);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) stim_q.push_back(1'b1);
      corr  = int'($urandom_range(0, 4));
      bad_f = int'($urandom_range(0, NF - 1));
      for (int f = 0; f < NF; f++) begin
        stop = 3'b111;
        if (corr == 3 && f == bad_f) stop[$urandom_range(0, 2)] = 1'b0;
        push_frame(8'($urandom), (corr == 4 && f == 1), stop);
      end
      push_postamble();
      mode = int'($urandom_range(0, 2));
      run_stream(mode, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the sequence is bounded, this only guards against a stall.
  initial begin
    #1000000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
